// File: rtl/pipeline_irq_controller.sv
// External interrupt controller feeding coprocessor 0: per-line synchronizer and
// pending bit, masked fixed-priority pick, and a request/service handshake FSM.

module pipeline_irq_lane (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic w1c,
  input  logic ack_clr,
  output logic pend
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise;

  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    // A fresh edge beats any clear landing on the same cycle.
    if (edge_mode) pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
    else           pend_d = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

module pipeline_irq_controller #(
  parameter int N_IRQ = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_data,
  input  logic             i_ack,
  input  logic             i_eret,
  output logic [31:0]      o_data,
  output logic             o_interrupt,
  output logic [3:0]       o_irq_id
);
  localparam logic [31:0] ADDR_PEND   = 32'h80;
  localparam logic [31:0] ADDR_MASK   = 32'h84;
  localparam logic [31:0] ADDR_EDGE   = 32'h88;
  localparam logic [31:0] ADDR_STATUS = 32'h8C;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  state_t           state_q, state_d;
  logic [3:0]       irq_id_q, irq_id_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] pend, w1c, ack_clr, active, id_onehot;
  logic [3:0]       winner;
  logic             id_active, busy;
  logic             unused_data;

  assign unused_data = ^i_data[31:N_IRQ];

  assign w1c = (i_we && i_addr == ADDR_PEND) ? i_data[N_IRQ-1:0] : '0;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_lane
    pipeline_irq_lane u_lane (
      .clk      (i_clk),
      .rst      (i_rst),
      .irq      (i_irq[g]),
      .edge_mode(edge_q[g]),
      .w1c      (w1c[g]),
      .ack_clr  (ack_clr[g]),
      .pend     (pend[g])
    );
  end

  assign active = pend & mask_q;

  always_comb begin
    winner = 4'd0;
    id_onehot = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = 4'(i);
    end
    for (int i = 0; i < N_IRQ; i++) begin
      id_onehot[i] = (irq_id_q == 4'(i));
    end
    id_active = |(active & id_onehot);
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (i_we && i_addr == ADDR_MASK) mask_d = i_data[N_IRQ-1:0];
    if (i_we && i_addr == ADDR_EDGE) edge_d = i_data[N_IRQ-1:0];
  end

  // o_irq_id is frozen from the pick in IDLE until the next pick.
  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    ack_clr     = '0;
    o_interrupt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|active) begin
          irq_id_d = winner;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        o_interrupt = 1'b1;
        if (i_ack) begin
          ack_clr = id_onehot & edge_q;
          state_d = S_SVC;
        end else if (!id_active) begin
          state_d = S_IDLE;
        end
      end
      S_SVC: begin
        if (i_eret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      irq_id_q <= 4'd0;
      mask_q   <= '0;
      edge_q   <= '1;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign o_irq_id = irq_id_q;

  always_comb begin
    case (i_addr)
      ADDR_PEND:   o_data = 32'(pend);
      ADDR_MASK:   o_data = 32'(mask_q);
      ADDR_EDGE:   o_data = 32'(edge_q);
      ADDR_STATUS: o_data = {27'b0, busy, irq_id_q};
      default:     o_data = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_pipeline_irq_controller.sv
// Directed bench for pipeline_irq_controller: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_pipeline_irq_controller;
  localparam int N = 8;
  localparam int SEL_INT = 0, SEL_ID = 1, SEL_DATA = 2;

  logic          clk = 1'b0;
  logic          i_rst, i_we, i_ack, i_eret;
  logic [N-1:0]  i_irq;
  logic [31:0]   i_addr, i_data, o_data;
  logic          o_interrupt;
  logic [3:0]    o_irq_id;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  pipeline_irq_controller #(.N_IRQ(N)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_irq      (i_irq),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .i_ack      (i_ack),
    .i_eret     (i_eret),
    .o_data     (o_data),
    .o_interrupt(o_interrupt),
    .o_irq_id   (o_irq_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      case (mon_e.sel)
        SEL_INT: mon_act = {31'b0, o_interrupt};
        SEL_ID:  mon_act = {28'b0, o_irq_id};
        default: mon_act = o_data;
      endcase
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", mon_e.name, mon_act, mon_e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_exp(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    i_addr = a;
    push_exp(SEL_DATA, v, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_data = d;
    tick();
    i_we = 1'b0; i_data = 32'h0;
  endtask

  initial begin
    i_rst = 1'b1; i_we = 1'b0; i_ack = 1'b0; i_eret = 1'b0;
    i_irq = '0; i_addr = 32'h0; i_data = 32'h0;
    ticks(2);

    // reset state
    push_exp(SEL_INT, 0, "rst_int");
    push_exp(SEL_ID, 0, "rst_id");
    rd(32'h80, 32'h00, "rst_pend"); tick();
    rd(32'h84, 32'h00, "rst_mask"); tick();
    rd(32'h88, 32'hFF, "rst_edge"); tick();
    rd(32'h8C, 32'h00, "rst_status"); tick();
    i_rst = 1'b0;

    // T1: single line, 4-edge latency, ack clears pending, eret idles
    wr(32'h84, 32'h01);
    i_irq = 8'h01; ticks(3);
    push_exp(SEL_INT, 0, "t1_int_before_e4");
    rd(32'h80, 32'h01, "t1_pend_set");
    i_irq = 8'h00; tick();
    push_exp(SEL_INT, 1, "t1_int_at_e4");
    push_exp(SEL_ID, 0, "t1_id");
    rd(32'h8C, 32'h10, "t1_status_busy");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    push_exp(SEL_INT, 0, "t1_int_after_ack");
    rd(32'h80, 32'h00, "t1_pend_cleared");
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    rd(32'h8C, 32'h00, "t1_status_idle"); tick();

    // T2: two lines same cycle, priority then gap then second
    wr(32'h84, 32'hFF);
    i_irq = 8'h24; ticks(3);
    i_irq = 8'h00; tick();
    push_exp(SEL_INT, 1, "t2_int");
    push_exp(SEL_ID, 2, "t2_id_first");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    rd(32'h80, 32'h20, "t2_pend5_left");
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    push_exp(SEL_INT, 0, "t2_gap");
    tick();
    push_exp(SEL_INT, 1, "t2_int_second");
    push_exp(SEL_ID, 5, "t2_id_second");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    rd(32'h80, 32'h00, "t2_pend_empty"); tick();

    // T3: software W1C withdraws an outstanding request
    wr(32'h84, 32'h08);
    i_irq = 8'h08; ticks(3);
    i_irq = 8'h00; tick();
    push_exp(SEL_INT, 1, "t3_req");
    push_exp(SEL_ID, 3, "t3_id");
    wr(32'h80, 32'h08);
    push_exp(SEL_INT, 1, "t3_still_req_at_write");
    tick();
    push_exp(SEL_INT, 0, "t3_withdrawn");
    rd(32'h8C, 32'h03, "t3_status_idle"); tick();

    // T4: level line re-requests after eret; drop follows three edges later
    wr(32'h88, 32'hFE);
    wr(32'h84, 32'h01);
    i_irq = 8'h01; ticks(4);
    push_exp(SEL_INT, 1, "t4_req");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    push_exp(SEL_INT, 0, "t4_svc");
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    push_exp(SEL_INT, 0, "t4_gap");
    tick();
    push_exp(SEL_INT, 1, "t4_rereq");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    i_irq = 8'h00; ticks(2);
    rd(32'h80, 32'h01, "t4_pend_hold"); tick();
    rd(32'h80, 32'h00, "t4_pend_drop");
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    tick();
    push_exp(SEL_INT, 0, "t4_no_new_req"); tick();

    // T5: edge during SERVICE is deferred; W1C vs edge on same cycle
    wr(32'h88, 32'hFF);
    wr(32'h84, 32'h02);
    i_irq = 8'h02; ticks(3);
    i_irq = 8'h00; tick();
    push_exp(SEL_INT, 1, "t5_req");
    push_exp(SEL_ID, 1, "t5_id");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    push_exp(SEL_INT, 0, "t5_svc");
    i_irq = 8'h02; ticks(3);
    i_irq = 8'h00;
    rd(32'h80, 32'h02, "t5_pend_in_svc");
    push_exp(SEL_INT, 0, "t5_low_in_svc");
    ticks(2);
    push_exp(SEL_INT, 0, "t5_still_low");
    rd(32'h8C, 32'h11, "t5_status_svc");
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    push_exp(SEL_INT, 0, "t5_gap");
    tick();
    push_exp(SEL_INT, 1, "t5_rereq");
    push_exp(SEL_ID, 1, "t5_rereq_id");
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    i_irq = 8'h10; ticks(2);
    wr(32'h80, 32'h10);
    rd(32'h80, 32'h10, "t5_w1c_vs_edge");
    push_exp(SEL_INT, 0, "t5_masked_no_req");
    tick();
    i_irq = 8'h00;
    wr(32'h80, 32'h10);
    rd(32'h80, 32'h00, "t5_w1c_clear"); tick();

    // T6: reset mid-request; ack/eret ignored in IDLE
    wr(32'h88, 32'hF0);
    wr(32'h84, 32'h04);
    i_irq = 8'h04; ticks(4);
    push_exp(SEL_INT, 1, "t6_req");
    push_exp(SEL_ID, 2, "t6_id");
    i_rst = 1'b1; i_irq = 8'h00; tick();
    push_exp(SEL_INT, 0, "t6_rst_int");
    push_exp(SEL_ID, 0, "t6_rst_id");
    rd(32'h8C, 32'h00, "t6_rst_status"); tick();
    rd(32'h84, 32'h00, "t6_rst_mask"); tick();
    rd(32'h88, 32'hFF, "t6_rst_edge");
    i_rst = 1'b0; tick();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    push_exp(SEL_INT, 0, "t6_ack_idle_int");
    rd(32'h8C, 32'h00, "t6_ack_idle_status"); tick();
    i_eret = 1'b1; tick(); i_eret = 1'b0;
    push_exp(SEL_INT, 0, "t6_eret_idle_int");
    rd(32'h8C, 32'h00, "t6_eret_idle_status"); tick();

    ticks(3);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
